// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter, control-word decode
// and halt latch. Control word is {Cp,Ep,n_Lm,n_CE,n_Li,n_Ei,n_La,Ea,Su,Eu,n_Lb,n_Lo}.
module sap1_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  t,
    output logic        hlt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [11:0] CON_IDLE     = 12'h3E3;
    localparam logic [11:0] CON_PC_MAR   = 12'h5E3;
    localparam logic [11:0] CON_PC_INC   = 12'hBE3;
    localparam logic [11:0] CON_RAM_IR   = 12'h263;
    localparam logic [11:0] CON_IR_MAR   = 12'h1A3;
    localparam logic [11:0] CON_RAM_A    = 12'h2C3;
    localparam logic [11:0] CON_RAM_B    = 12'h2E1;
    localparam logic [11:0] CON_ADD_A    = 12'h3C7;
    localparam logic [11:0] CON_SUB_A    = 12'h3CF;
    localparam logic [11:0] CON_A_OUT    = 12'h3F2;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    ring_e ring_q;
    ring_e ring_d;
    logic  hlt_d;
    logic  run;

    assign run = en && !hlt;
    assign t   = ring_q;

    always_comb begin
        ring_d = ring_q;
        hlt_d  = hlt;
        if (run) begin
            case (ring_q)
                T1: ring_d = T2;
                T2: ring_d = T3;
                T3: ring_d = T4;
                T4: begin
                    if (opcode == OP_HLT) hlt_d = 1'b1;
                    else                  ring_d = T5;
                end
                T5: ring_d = T6;
                T6: ring_d = T1;
                // Any corrupted, non-one-hot ring value restarts the fetch.
                default: ring_d = T1;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ring_q <= T1;
            hlt    <= 1'b0;
        end else begin
            ring_q <= ring_d;
            hlt    <= hlt_d;
        end
    end

    // Paused or halted sequencing emits the idle word so Cp cannot repeat.
    always_comb begin
        con = CON_IDLE;
        if (run) begin
            case (ring_q)
                T1: con = CON_PC_MAR;
                T2: con = CON_PC_INC;
                T3: con = CON_RAM_IR;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: con = CON_IR_MAR;
                        OP_OUT:                 con = CON_A_OUT;
                        default:                con = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         con = CON_RAM_A;
                        OP_ADD, OP_SUB: con = CON_RAM_B;
                        default:        con = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  con = CON_ADD_A;
                        OP_SUB:  con = CON_SUB_A;
                        default: con = CON_IDLE;
                    endcase
                end
                default: con = CON_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sap1_controller.sv
// Directed self-checking bench for sap1_controller: fetch/execute words per opcode,
// step gating, halt, mid-instruction reset and a continuous bus-exclusivity monitor.
module tb_sap1_controller;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t;
    logic        hlt;

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;
    int bus_drivers;

    sap1_controller dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .opcode (opcode),
        .con    (con),
        .t      (t),
        .hlt    (hlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ep, n_CE=0, n_Ei=0, Ea and Eu all drive the bus; at most one may be active.
    always @(negedge clk) begin
        if (mon_on) begin
            bus_drivers = $countones({con[10], ~con[8], ~con[6], con[4], con[2]});
            checks++;
            if (bus_drivers > 1) begin
                failures++;
                $display("FAIL bus_excl t=%b con=%h drivers=%0d required<=1", t, con, bus_drivers);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] exp_con [7] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3};
        logic [5:0]  exp_t;
        rst = 1'b0; en = 1'b1; opcode = 4'b0000;
        tick();
        tick();
        checks++;
        if (t !== 6'b000001) begin failures++; $display("FAIL reset_t got=%b exp=000001", t); end
        checks++;
        if (hlt !== 1'b0) begin failures++; $display("FAIL reset_hlt got=%b exp=0", hlt); end
        checks++;
        if (con !== 12'h5E3) begin failures++; $display("FAIL reset_con got=%h exp=5E3", con); end
        mon_on = 1'b1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            exp_t = 6'b000001 << (i % 6);
            checks++;
            if (con !== exp_con[i]) begin failures++; $display("FAIL lda_con step=%0d got=%h exp=%h", i, con, exp_con[i]); end
            checks++;
            if (t !== exp_t) begin failures++; $display("FAIL lda_t step=%0d got=%b exp=%b", i, t, exp_t); end
            if (i < 6) tick();
        end
    endtask

    task automatic test_add_sub();
        logic [11:0] exp_add [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7};
        logic [11:0] exp_sub [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3CF};
        logic [5:0]  exp_t;
        opcode = 4'b0001;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_t = 6'b000001 << i;
            checks++;
            if (con !== exp_add[i]) begin failures++; $display("FAIL add_con step=%0d got=%h exp=%h", i, con, exp_add[i]); end
            checks++;
            if (t !== exp_t) begin failures++; $display("FAIL add_t step=%0d got=%b exp=%b", i, t, exp_t); end
            tick();
        end
        opcode = 4'b0010;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_t = 6'b000001 << i;
            checks++;
            if (con !== exp_sub[i]) begin failures++; $display("FAIL sub_con step=%0d got=%h exp=%h", i, con, exp_sub[i]); end
            checks++;
            if (t !== exp_t) begin failures++; $display("FAIL sub_t step=%0d got=%b exp=%b", i, t, exp_t); end
            tick();
        end
    endtask

    task automatic test_out();
        logic [11:0] exp_out [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3F2, 12'h3E3, 12'h3E3};
        int nlo_low = 0;
        opcode = 4'b1110;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (con !== exp_out[i]) begin failures++; $display("FAIL out_con step=%0d got=%h exp=%h", i, con, exp_out[i]); end
            if (con[0] === 1'b0) nlo_low++;
            tick();
        end
        checks++;
        if (nlo_low !== 1) begin failures++; $display("FAIL out_nlo_cycles got=%0d exp=1", nlo_low); end
    endtask

    task automatic test_step_gating();
        logic [11:0] exp_rest [5] = '{12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3};
        opcode = 4'b0000;
        #1;
        checks++;
        if (con !== 12'h5E3) begin failures++; $display("FAIL gate_t1 got=%h exp=5E3", con); end
        tick();
        checks++;
        if (con !== 12'hBE3) begin failures++; $display("FAIL gate_t2 got=%h exp=BE3", con); end
        en = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (t !== 6'b000010) begin failures++; $display("FAIL gate_hold_t cyc=%0d got=%b exp=000010", i, t); end
            checks++;
            if (con !== 12'h3E3) begin failures++; $display("FAIL gate_hold_con cyc=%0d got=%h exp=3E3", i, con); end
            if (i < 5) tick();
        end
        en = 1'b1;
        #1;
        checks++;
        if (con !== 12'hBE3) begin failures++; $display("FAIL gate_resume got=%h exp=BE3", con); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (con !== exp_rest[i]) begin failures++; $display("FAIL gate_seq step=%0d got=%h exp=%h", i, con, exp_rest[i]); end
        end
    endtask

    task automatic test_halt();
        logic [11:0] exp_fetch [4] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3E3};
        opcode = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (con !== exp_fetch[i]) begin failures++; $display("FAIL hlt_con step=%0d got=%h exp=%h", i, con, exp_fetch[i]); end
            checks++;
            if (hlt !== 1'b0) begin failures++; $display("FAIL hlt_early step=%0d got=%b exp=0", i, hlt); end
            if (i < 3) tick();
        end
        tick();
        checks++;
        if (hlt !== 1'b1) begin failures++; $display("FAIL hlt_set got=%b exp=1", hlt); end
        for (int i = 0; i < 20; i++) begin
            en = ((i % 2) == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (t !== 6'b001000) begin failures++; $display("FAIL hlt_hold_t cyc=%0d got=%b exp=001000", i, t); end
            checks++;
            if (con !== 12'h3E3) begin failures++; $display("FAIL hlt_hold_con cyc=%0d got=%h exp=3E3", i, con); end
            checks++;
            if (hlt !== 1'b1) begin failures++; $display("FAIL hlt_hold cyc=%0d got=%b exp=1", i, hlt); end
        end
        en = 1'b1;
        rst = 1'b0;
        tick();
        checks++;
        if (hlt !== 1'b0) begin failures++; $display("FAIL hlt_clear got=%b exp=0", hlt); end
        checks++;
        if (t !== 6'b000001) begin failures++; $display("FAIL hlt_reset_t got=%b exp=000001", t); end
        rst = 1'b1;
        #1;
        checks++;
        if (con !== 12'h5E3) begin failures++; $display("FAIL hlt_reset_con got=%h exp=5E3", con); end
    endtask

    task automatic test_reset_midop_bad_opcode();
        logic [11:0] exp_nop [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3E3, 12'h3E3, 12'h3E3};
        opcode = 4'b0001;
        #1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (con !== 12'h2E1 || t !== 6'b010000) begin
            failures++; $display("FAIL midop_t5 got con=%h t=%b exp con=2E1 t=010000", con, t);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (t !== 6'b000001) begin failures++; $display("FAIL midop_t got=%b exp=000001", t); end
        checks++;
        if (con !== 12'h5E3) begin failures++; $display("FAIL midop_con got=%h exp=5E3", con); end
        rst = 1'b1;
        opcode = 4'b0101;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (con !== exp_nop[i]) begin failures++; $display("FAIL nop_con step=%0d got=%h exp=%h", i, con, exp_nop[i]); end
            tick();
        end
        checks++;
        if (t !== 6'b000001 || con !== 12'h5E3) begin
            failures++; $display("FAIL nop_wrap got t=%b con=%h exp t=000001 con=5E3", t, con);
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        opcode = 4'b0000;
        test_reset();
        test_add_sub();
        test_out();
        test_step_gating();
        test_halt();
        test_reset_midop_bad_opcode();
        tick();
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
- Controller-sequencer for the SAP-1 datapath.
- A six-state one-hot ring counter (T1..T6) steps the fetch/execute cycle.
- Each T-state is decoded, together with the IR opcode nibble, into the 12-bit control word. That word drives PC, MAR, RAM, IR, A, B, ALU and output-register load/enable pins; the ALS_CI74173-style registers take active-low loads and active-high output enables.
- The controller also owns the halt latch.

Parameters:
OP_LDA, 4'b0000, opcode: load A from memory
OP_ADD, 4'b0001, opcode: A <= A + mem
OP_SUB, 4'b0010, opcode: A <= A - mem
OP_OUT, 4'b1110, opcode: A -> output register
OP_HLT, 4'b1111, opcode: stop sequencing

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst=0 at posedge resets)
en  input  1  run/step enable; 0 freezes ring and forces the inactive control word
opcode  input  4  IR[7:4]; stable from the T3 edge through T6
con  output  12  {Cp,Ep,n_Lm,n_CE,n_Li,n_Ei,n_La,Ea,Su,Eu,n_Lb,n_Lo}
t  output  6  ring state, one-hot, t[0]=T1 .. t[5]=T6
hlt  output  1  halted flag (registered)

Behaviour:
- Reset (rst=0 at posedge, priority over everything): t=6'b000001, hlt=0. con then equals the T1 word 12'h5E3.
- Inactive word: 12'h3E3 (all n_* high, all active-high bits low).
- Ring advance: at each posedge with rst=1, en=1, hlt=0, T1->T2->...->T6->T1. This gives one instruction every 6 clocks, for every opcode.
- Frozen states: ring holds when en=0 or hlt=1.
- Illegal ring state: any non-one-hot value of t returns to T1 on the next enabled edge, and con is 12'h3E3 while in it.
- con is combinational from t, opcode, en and hlt. It is forced to 12'h3E3 when en=0 or hlt=1. This prevents repeated PC increments while stepping is paused.
- Fetch words, all opcodes:
  - T1 = 12'h5E3 (Ep, n_Lm)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (n_CE, n_Li)
- LDA: T4 = 12'h1A3 (n_Ei, n_Lm); T5 = 12'h2C3 (n_CE, n_La); T6 = 12'h3E3.
- ADD: T4 = 12'h1A3; T5 = 12'h2E1 (n_CE, n_Lb); T6 = 12'h3C7 (Eu, n_La).
- SUB: as ADD, except T6 = 12'h3CF (Su, Eu, n_La). Su is asserted only in T6.
- OUT: T4 = 12'h3F2 (Ea, n_Lo); T5 and T6 = 12'h3E3.
- HLT:
  - T4 con = 12'h3E3.
  - At the enabled posedge in T4, hlt<=1 and the ring stays at T4.
  - The halt persists until reset; en has no effect while halted.
- Undefined opcodes (0011..1101): T4..T6 = 12'h3E3 (NOP), and sequencing continues.
- Reset mid-instruction: the ring returns to T1 on that edge with no partial execute word. The controller does not reset PC or registers.
- Bus exclusivity: at most one of Ep, n_CE=0, n_Ei=0, Ea, Eu is active in any state. The bench checks this every cycle.

Test Plan:
- Reset: hold rst=0 for 2 clocks, then release with en=1 and opcode=OP_LDA. Required: t=000001 and con=5E3 on the first cycle, then 6-cycle con sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to 5E3.
- ADD then SUB: opcode=0001 for one instruction, then 0010. Required: T5=2E1 and T6=3C7 for ADD; T6=3CF for SUB; T1..T5 identical for both.
- OUT: opcode=1110. Required: T4=3F2, T5=T6=3E3; n_Lo low for exactly one cycle per instruction.
- HLT: opcode=1111. Required:
  - T4 con=3E3; hlt=1 after the T4 edge.
  - t stays 001000 and con stays 3E3 for 20 more clocks, including with en toggling.
  - rst=0 for one edge clears hlt and gives t=000001.
- Step gating: drop en=0 during T2 for 5 clocks. Required: t holds at 000010, con=3E3 throughout (Cp not pulsed), and the sequence resumes at T2=BE3 when en=1.
- Reset mid-op and bad opcode: assert rst=0 in T5 of an ADD. Required: next cycle t=000001, con=5E3. Then run opcode=0101. Required: T4..T6=3E3, and the ring wraps to T1. The bus-exclusivity assertion holds throughout.
